// File: rtl/icache_pkg.sv
// Shared definitions for the set-associative instruction cache: FSM encodings,
// AXI4 constants and address-field width helpers.
package icache_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOOKUP = 3'd1;
  localparam logic [2:0] ST_AR     = 3'd2;
  localparam logic [2:0] ST_REFILL = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] OKAY       = 2'b00;

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int off_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int tag_w(input int sets, input int line_words);
    return 32 - idx_w(sets) - off_w(line_words);
  endfunction

endpackage

// File: rtl/icache_way.sv
// One way of the cache: per-set valid bit, tag and line storage with an
// asynchronous read port, a synchronous write port and a global invalidate.
module icache_way #(
  parameter int SETS       = 4,
  parameter int LINE_WORDS = 2,
  parameter int IDX_W      = 2,
  parameter int WRD_W      = 1,
  parameter int TAG_W      = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inv,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [WRD_W-1:0] rd_word,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WRD_W-1:0] wr_word,
  input  logic [31:0]      wr_data,
  input  logic             data_we,
  input  logic             tag_we,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_valid
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS][LINE_WORDS];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx][rd_word];

  // Invalidate wins over a same-cycle line install so a flushed refill never lands valid.
  always_ff @(posedge clk) begin
    if (rst || inv) begin
      valid_q <= '0;
    end else if (tag_we) begin
      valid_q[wr_idx] <= wr_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we) tag_q[wr_idx] <= wr_tag;
    if (data_we) data_q[wr_idx][wr_word] <= wr_data;
  end

endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache: IFU valid/ready fetch port in front, AXI4
// burst read master behind, round-robin replacement and fence.i flush.
module icache_sa
  import icache_pkg::*;
#(
  parameter int SETS       = 4,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 2,
  parameter int AXI_ID     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  output logic [3:0]  arid,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  input  logic        rlast,
  input  logic [3:0]  rid
);

  localparam int IDX_W = idx_w(SETS);
  localparam int OFF_W = off_w(LINE_WORDS);
  localparam int TAG_W = tag_w(SETS, LINE_WORDS);
  localparam int WRD_W = OFF_W - 2;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [3:0] ID = 4'(AXI_ID);

  logic [2:0]       state;
  logic [31:2]      addr_q;
  logic [WRD_W-1:0] beat_q;
  logic             err_q;
  logic             kill_q;
  logic [WAY_W-1:0] victim_q;
  logic [WAY_W-1:0] rr_ptr [SETS];
  logic [31:0]      resp_data_q;
  logic             resp_err_q;

  logic [IDX_W-1:0] idx;
  logic [WRD_W-1:0] word;
  logic [TAG_W-1:0] tag;
  logic             unused_addr_bits;

  assign idx  = addr_q[OFF_W +: IDX_W];
  assign word = addr_q[2 +: WRD_W];
  assign tag  = addr_q[31 -: TAG_W];
  assign unused_addr_bits = ^req_addr[1:0];

  logic [WAYS-1:0]  way_valid;
  logic [TAG_W-1:0] way_tag  [WAYS];
  logic [31:0]      way_data [WAYS];
  logic [WAYS-1:0]  data_we;
  logic [WAYS-1:0]  tag_we;
  logic             line_ok;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way #(
      .SETS(SETS), .LINE_WORDS(LINE_WORDS), .IDX_W(IDX_W), .WRD_W(WRD_W), .TAG_W(TAG_W)
    ) u_way (
      .clk(clk), .rst(rst), .inv(flush),
      .rd_idx(idx), .rd_word(word),
      .rd_valid(way_valid[w]), .rd_tag(way_tag[w]), .rd_data(way_data[w]),
      .wr_idx(idx), .wr_word(beat_q), .wr_data(rdata),
      .data_we(data_we[w]), .tag_we(tag_we[w]), .wr_tag(tag), .wr_valid(line_ok)
    );
  end

  logic             hit;
  logic [31:0]      hit_data;
  logic [WAY_W-1:0] victim;
  logic             beat_fire;
  logic             err_next;

  assign beat_fire = (state == ST_REFILL) && rvalid && (rid == ID);
  assign err_next  = err_q || (rresp != OKAY);
  assign line_ok   = !err_next && !kill_q && !flush;

  // A flush in LOOKUP forces a miss; lowest invalid way beats the round-robin pointer.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    victim   = rr_ptr[idx];
    for (int w = 0; w < WAYS; w++) begin
      if (way_valid[w] && (way_tag[w] == tag)) begin
        hit      = 1'b1;
        hit_data = way_data[w];
      end
    end
    hit = hit && !flush;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) victim = WAY_W'(w);
    end
  end

  always_comb begin
    data_we = '0;
    tag_we  = '0;
    for (int w = 0; w < WAYS; w++) begin
      data_we[w] = beat_fire && (victim_q == WAY_W'(w));
      tag_we[w]  = beat_fire && rlast && (victim_q == WAY_W'(w));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      beat_q      <= '0;
      err_q       <= 1'b0;
      kill_q      <= 1'b0;
      victim_q    <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
    end else begin
      if (flush && (state == ST_AR || state == ST_REFILL)) kill_q <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr[31:2];
            err_q  <= 1'b0;
            kill_q <= 1'b0;
            state  <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (hit) begin
            resp_data_q <= hit_data;
            resp_err_q  <= 1'b0;
            state       <= ST_RESP;
          end else begin
            victim_q <= victim;
            state    <= ST_AR;
          end
        end
        ST_AR: begin
          if (arready) begin
            beat_q <= '0;
            state  <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (beat_fire) begin
            beat_q <= beat_q + 1'b1;
            err_q  <= err_next;
            if (beat_q == word) resp_data_q <= rdata;
            if (rlast) begin
              resp_err_q <= err_next;
              if (err_next) resp_data_q <= '0;
              rr_ptr[idx] <= (WAYS == 1) ? '0 : rr_ptr[idx] + 1'b1;
              state <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (resp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state == ST_IDLE) && !rst;
  assign resp_valid = (state == ST_RESP);
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign arvalid    = (state == ST_AR);
  assign araddr     = arvalid ? {addr_q[31:OFF_W], {OFF_W{1'b0}}} : 32'h0;
  assign arid       = ID;
  assign arlen      = 8'(LINE_WORDS - 1);
  assign arsize     = SIZE_4B;
  assign arburst    = BURST_INCR;
  assign rready     = (state == ST_REFILL);

endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa with default geometry (4 sets, 2 ways, 2-word lines).
module tb_icache_sa;

  logic        clk = 1'b0;
  logic        rst, flush, req_valid, resp_ready, arready, rvalid, rlast;
  logic [31:0] req_addr, rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic        req_ready, resp_valid, resp_err, arvalid, rready;
  logic [31:0] resp_data, araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  icache_sa #(.SETS(4), .WAYS(2), .LINE_WORDS(2), .AXI_ID(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready), .rlast(rlast), .rid(rid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
  endtask

  // Full fetch transaction with an ideal AXI slave; optionally flush/error on beat 0.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [1:0] rr0, input logic fl0,
                       output logic ok, output logic saw_ar, output logic [31:0] ar_a,
                       output logic [31:0] data, output logic err);
    ok = 1'b0; saw_ar = 1'b0; ar_a = '0; data = '0; err = 1'b0;
    req_valid = 1'b1;
    req_addr  = addr;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (req_valid && req_ready) begin
        tick();
        req_valid = 1'b0;
      end else if (arvalid) begin
        saw_ar = 1'b1; ar_a = araddr;
        arready = 1'b1; tick(); arready = 1'b0;
        rvalid = 1'b1; rid = 4'd1; rdata = d0; rresp = rr0; rlast = 1'b0; flush = fl0;
        tick();
        flush = 1'b0; rdata = d1; rresp = 2'b00; rlast = 1'b1;
        tick();
        rvalid = 1'b0; rlast = 1'b0;
      end else if (resp_valid) begin
        data = resp_data; err = resp_err;
        resp_ready = 1'b1; tick(); resp_ready = 1'b0;
        ok = 1'b1;
      end else begin
        tick();
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL rst_req_ready got %b want 0", req_ready); end
    vectors++; if (arvalid !== 1'b0) begin miscompares++; $display("FAIL rst_arvalid got %b want 0", arvalid); end
    vectors++; if (rready !== 1'b0) begin miscompares++; $display("FAIL rst_rready got %b want 0", rready); end
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
    vectors++; if (resp_data !== 32'h0) begin miscompares++; $display("FAIL rst_resp_data got %h want 0", resp_data); end
    vectors++; if (resp_err !== 1'b0) begin miscompares++; $display("FAIL rst_resp_err got %b want 0", resp_err); end
    rst = 1'b0;
    tick();
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL idle_req_ready got %b want 1", req_ready); end
  endtask

  task automatic test_cold_miss();
    logic [31:0] a_addr;
    logic        got;
    req_valid = 1'b1; req_addr = 32'h8000_0004;
    tick();
    req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (arvalid) got = 1'b1; else tick();
    end
    vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL cold_ar_seen got %b want 1", got); end
    a_addr = araddr;
    vectors++; if (a_addr !== 32'h8000_0000) begin miscompares++; $display("FAIL cold_araddr got %h want 80000000", a_addr); end
    vectors++; if (arlen !== 8'd1) begin miscompares++; $display("FAIL cold_arlen got %0d want 1", arlen); end
    vectors++; if (arsize !== 3'd2) begin miscompares++; $display("FAIL cold_arsize got %0d want 2", arsize); end
    vectors++; if (arburst !== 2'd1) begin miscompares++; $display("FAIL cold_arburst got %0d want 1", arburst); end
    vectors++; if (arid !== 4'd1) begin miscompares++; $display("FAIL cold_arid got %0d want 1", arid); end
    arready = 1'b1; tick(); arready = 1'b0;
    vectors++; if (rready !== 1'b1) begin miscompares++; $display("FAIL cold_rready got %b want 1", rready); end
    rvalid = 1'b1; rid = 4'd1; rdata = 32'hAAAA_0000; rresp = 2'b00; rlast = 1'b0;
    tick();
    rdata = 32'hBBBB_0001; rlast = 1'b1;
    tick();
    rvalid = 1'b0; rlast = 1'b0;
    vectors++; if (resp_valid !== 1'b1) begin miscompares++; $display("FAIL cold_resp_valid got %b want 1", resp_valid); end
    vectors++; if (resp_data !== 32'hBBBB_0001) begin miscompares++; $display("FAIL cold_resp_data got %h want bbbb0001", resp_data); end
    vectors++; if (resp_err !== 1'b0) begin miscompares++; $display("FAIL cold_resp_err got %b want 0", resp_err); end
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
  endtask

  task automatic test_hit_and_backpressure();
    req_valid = 1'b1; req_addr = 32'h8000_0004;
    tick();
    req_valid = 1'b0;
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL hit_lookup_valid got %b want 0", resp_valid); end
    tick();
    vectors++; if (resp_valid !== 1'b1) begin miscompares++; $display("FAIL hit_resp_valid got %b want 1", resp_valid); end
    vectors++; if (resp_data !== 32'hBBBB_0001) begin miscompares++; $display("FAIL hit_resp_data got %h want bbbb0001", resp_data); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (resp_valid !== 1'b1) begin miscompares++; $display("FAIL bp_resp_valid got %b want 1", resp_valid); end
      vectors++; if (resp_data !== 32'hBBBB_0001) begin miscompares++; $display("FAIL bp_resp_data got %h want bbbb0001", resp_data); end
      vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL bp_req_ready got %b want 0", req_ready); end
      vectors++; if (arvalid !== 1'b0) begin miscompares++; $display("FAIL bp_arvalid got %b want 0", arvalid); end
    end
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release_valid got %b want 0", resp_valid); end
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready got %b want 1", req_ready); end
  endtask

  task automatic test_eviction();
    logic ok, saw, err;
    logic [31:0] a, d;
    do_reset();
    rst = 1'b0;
    tick();
    fetch(32'h8000_0000, 32'h0000_1000, 32'h0000_1001, 2'b00, 1'b0, ok, saw, a, d, err);
    vectors++; if (saw !== 1'b1) begin miscompares++; $display("FAIL evict_fill0_ar got %b want 1", saw); end
    fetch(32'h8000_0020, 32'h0000_2000, 32'h0000_2001, 2'b00, 1'b0, ok, saw, a, d, err);
    vectors++; if (a !== 32'h8000_0020) begin miscompares++; $display("FAIL evict_fill1_araddr got %h want 80000020", a); end
    fetch(32'h8000_0040, 32'h0000_4000, 32'h0000_4001, 2'b00, 1'b0, ok, saw, a, d, err);
    vectors++; if (d !== 32'h0000_4000) begin miscompares++; $display("FAIL evict_fill2_data got %h want 00004000", d); end
    fetch(32'h8000_0020, 32'hDEAD_0000, 32'hDEAD_0001, 2'b00, 1'b0, ok, saw, a, d, err);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL evict_hit_done got %b want 1", ok); end
    vectors++; if (saw !== 1'b0) begin miscompares++; $display("FAIL evict_way1_kept got ar=%b want 0", saw); end
    vectors++; if (d !== 32'h0000_2000) begin miscompares++; $display("FAIL evict_hit_data got %h want 00002000", d); end
    fetch(32'h8000_0000, 32'h0000_5000, 32'h0000_5001, 2'b00, 1'b0, ok, saw, a, d, err);
    vectors++; if (saw !== 1'b1) begin miscompares++; $display("FAIL evict_way0_gone got ar=%b want 1", saw); end
  endtask

  task automatic test_flush_refill();
    logic ok, saw, err;
    logic [31:0] a, d;
    fetch(32'h8000_000C, 32'hF000_0000, 32'hF000_0001, 2'b00, 1'b1, ok, saw, a, d, err);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL flush_resp_done got %b want 1", ok); end
    vectors++; if (d !== 32'hF000_0001) begin miscompares++; $display("FAIL flush_resp_data got %h want f0000001", d); end
    fetch(32'h8000_000C, 32'hF000_0000, 32'hF000_0001, 2'b00, 1'b0, ok, saw, a, d, err);
    vectors++; if (saw !== 1'b1) begin miscompares++; $display("FAIL flush_refetch_miss got ar=%b want 1", saw); end
    fetch(32'h8000_0000, 32'h0000_5000, 32'h0000_5001, 2'b00, 1'b0, ok, saw, a, d, err);
    vectors++; if (saw !== 1'b1) begin miscompares++; $display("FAIL flush_other_set_cleared got ar=%b want 1", saw); end
  endtask

  task automatic test_axi_error();
    logic ok, saw, err;
    logic [31:0] a, d;
    fetch(32'h8000_0010, 32'hE0E0_E0E0, 32'hE1E1_E1E1, 2'b10, 1'b0, ok, saw, a, d, err);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err_flag got %b want 1", err); end
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL err_data got %h want 0", d); end
    fetch(32'h8000_0010, 32'hE0E0_E0E0, 32'hE1E1_E1E1, 2'b00, 1'b0, ok, saw, a, d, err);
    vectors++; if (saw !== 1'b1) begin miscompares++; $display("FAIL err_refetch_ar got %b want 1", saw); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL err_refetch_flag got %b want 0", err); end
    vectors++; if (d !== 32'hE0E0_E0E0) begin miscompares++; $display("FAIL err_refetch_data got %h want e0e0e0e0", d); end
  endtask

  task automatic test_arready_stall_and_reset();
    do_reset();
    rst = 1'b0;
    tick();
    req_valid = 1'b1; req_addr = 32'h8000_0008;
    tick();
    req_valid = 1'b0;
    tick();
    vectors++; if (arvalid !== 1'b1) begin miscompares++; $display("FAIL stall_arvalid got %b want 1", arvalid); end
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++; if (arvalid !== 1'b1) begin miscompares++; $display("FAIL stall_hold_arvalid got %b want 1", arvalid); end
      vectors++; if (araddr !== 32'h8000_0008) begin miscompares++; $display("FAIL stall_hold_araddr got %h want 80000008", araddr); end
    end
    arready = 1'b1; tick(); arready = 1'b0;
    vectors++; if (rready !== 1'b1) begin miscompares++; $display("FAIL stall_refill_rready got %b want 1", rready); end
    rvalid = 1'b1; rid = 4'd1; rdata = 32'h1234_5678; rresp = 2'b00; rlast = 1'b0;
    rst = 1'b1;
    tick();
    rvalid = 1'b0;
    vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_req_ready got %b want 0", req_ready); end
    vectors++; if (arvalid !== 1'b0) begin miscompares++; $display("FAIL midrst_arvalid got %b want 0", arvalid); end
    vectors++; if (araddr !== 32'h0) begin miscompares++; $display("FAIL midrst_araddr got %h want 0", araddr); end
    vectors++; if (rready !== 1'b0) begin miscompares++; $display("FAIL midrst_rready got %b want 0", rready); end
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_resp_valid got %b want 0", resp_valid); end
    vectors++; if (resp_data !== 32'h0) begin miscompares++; $display("FAIL midrst_resp_data got %h want 0", resp_data); end
    vectors++; if (resp_err !== 1'b0) begin miscompares++; $display("FAIL midrst_resp_err got %b want 0", resp_err); end
    rst = 1'b0;
    tick();
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL postrst_req_ready got %b want 1", req_ready); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rresp = 2'b00; rid = 4'd0;
    test_reset();
    test_cold_miss();
    test_hit_and_backpressure();
    test_eviction();
    test_flush_refill();
    test_axi_error();
    test_arready_stall_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
